// File: rtl/pu_pkg.sv
// Shared constants and FSM encoding for the PU layer sequencer and its counters.
package pu_pkg;
    localparam int LANES    = 8;
    localparam int LANE_W   = 8;
    localparam int CHUNK_W  = LANES * LANE_W;
    localparam int RESULT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } seq_state_t;
endpackage

// File: rtl/pu_seq_counters.sv
// Chunk / neuron / weight-address counters for one layer pass; hold unless advanced.
module pu_seq_counters
    import pu_pkg::*;
#(
    parameter int CW      = 5,
    parameter int NW      = 7,
    parameter int WADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    input  logic [CW-1:0]      num_chunks,
    output logic [CW-1:0]      chunk,
    output logic [NW-1:0]      neuron,
    output logic [WADDR_W-1:0] waddr,
    output logic               last_chunk
);
    logic [CW-1:0]      chunk_q, chunk_d;
    logic [NW-1:0]      neuron_q, neuron_d;
    logic [WADDR_W-1:0] waddr_q, waddr_d;

    assign last_chunk = (chunk_q == num_chunks - CW'(1));
    assign chunk      = chunk_q;
    assign neuron     = neuron_q;
    assign waddr      = waddr_q;

    always_comb begin
        chunk_d  = chunk_q;
        neuron_d = neuron_q;
        waddr_d  = waddr_q;
        if (clear) begin
            chunk_d  = '0;
            neuron_d = '0;
            waddr_d  = '0;
        end else if (advance) begin
            // The weight address runs linearly across neurons: n*k + c.
            waddr_d = waddr_q + WADDR_W'(1);
            if (last_chunk) begin
                chunk_d  = '0;
                neuron_d = neuron_q + NW'(1);
            end else begin
                chunk_d = chunk_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chunk_q  <= '0;
            neuron_q <= '0;
            waddr_q  <= '0;
        end else begin
            chunk_q  <= chunk_d;
            neuron_q <= neuron_d;
            waddr_q  <= waddr_d;
        end
    end
endmodule

// File: rtl/pu_layer_sequencer.sv
// Sequences one fully-connected layer through an 8-lane PU and writes ReLU results.
// Optional PU_SEQ_PERF_EN adds busy/stall performance counters.
module pu_layer_sequencer
    import pu_pkg::*;
#(
    parameter  int MAX_CHUNKS  = 16,
    parameter  int MAX_NEURONS = 64,
    parameter  int WADDR_W     = 10,
    localparam int CW          = $clog2(MAX_CHUNKS + 1),
    localparam int NW          = $clog2(MAX_NEURONS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CW-1:0]       num_chunks,
    input  logic [NW-1:0]       num_neurons,
    output logic                busy,
    output logic                done,
    output logic [CW-1:0]       in_addr,
    output logic [WADDR_W-1:0]  wt_addr,
    output logic [NW-1:0]       bias_addr,
    input  logic [CHUNK_W-1:0]  in_mem_data,
    input  logic [CHUNK_W-1:0]  wt_mem_data,
    input  logic [LANE_W-1:0]   bias_mem_data,
    output logic [CHUNK_W-1:0]  pu_in_data,
    output logic [CHUNK_W-1:0]  pu_weights,
    output logic [LANE_W-1:0]   pu_bias,
    output logic                pu_bias_sel,
    output logic                pu_flush,
    input  logic                pu_results_ready,
    input  logic [RESULT_W-1:0] pu_result,
`ifdef PU_SEQ_PERF_EN
    output logic [31:0]         perf_busy_cycles,
    output logic [31:0]         perf_stall_cycles,
`endif
    output logic                res_we,
    output logic [NW-1:0]       res_addr,
    output logic [RESULT_W-1:0] res_data
);
    seq_state_t         state_q, state_d;
    logic [CW-1:0]      k_q, k_d;
    logic [NW-1:0]      n_q, n_d;
    logic [NW-1:0]      wcnt_q, wcnt_d;
    logic [CW-1:0]      chunk;
    logic [NW-1:0]      neuron;
    logic [WADDR_W-1:0] waddr;
    logic               last_chunk;
    logic               issue, advance, last_neuron;

    assign issue       = (state_q == S_ISSUE);
    // results_ready doubles as the PU stall, so nothing is accepted while it is high.
    assign advance     = issue && !pu_results_ready;
    assign last_neuron = (neuron == n_q - NW'(1));

    pu_seq_counters #(
        .CW      (CW),
        .NW      (NW),
        .WADDR_W (WADDR_W)
    ) u_counters (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_q == S_FLUSH),
        .advance    (advance),
        .num_chunks (k_q),
        .chunk      (chunk),
        .neuron     (neuron),
        .waddr      (waddr),
        .last_chunk (last_chunk)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_d      = n_q;
        wcnt_d   = wcnt_q;
        busy     = (state_q != S_IDLE);
        done     = 1'b0;
        pu_flush = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FLUSH;
                    k_d     = num_chunks;
                    n_d     = num_neurons;
                end
            end
            S_FLUSH: begin
                pu_flush = 1'b1;
                wcnt_d   = '0;
                state_d  = (k_q == '0 || n_q == '0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                if (advance && last_chunk && last_neuron) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (wcnt_q == n_q) state_d = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                pu_flush = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        res_we = pu_results_ready && (issue || state_q == S_DRAIN);
        if (res_we) wcnt_d = wcnt_q + NW'(1);
    end

    // Operands are zeroed outside ISSUE so the PU accumulator sees harmless bubbles.
    assign in_addr     = issue ? chunk : '0;
    assign wt_addr     = issue ? waddr : '0;
    assign bias_addr   = issue ? neuron : '0;
    assign pu_in_data  = issue ? in_mem_data : '0;
    assign pu_weights  = issue ? wt_mem_data : '0;
    assign pu_bias     = issue ? bias_mem_data : '0;
    assign pu_bias_sel = issue && last_chunk;
    assign res_addr    = res_we ? wcnt_q : '0;
    assign res_data    = res_we ? pu_result : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            wcnt_q  <= wcnt_d;
        end
    end

`ifdef PU_SEQ_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if (state_q == S_IDLE && start) begin
            perf_busy_d  = '0;
            perf_stall_d = '0;
        end else begin
            if (busy && perf_busy_q != '1) perf_busy_d = perf_busy_q + 32'd1;
            if (issue && pu_results_ready && perf_stall_q != '1)
                perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_busy_cycles  = perf_busy_q;
    assign perf_stall_cycles = perf_stall_q;
`endif
endmodule
